// File: rtl/sd_modulator_tx.sv
// Sigma-delta bitstream transmitter: signed samples in via valid/ready, 1-bit SD clock/data out.
// Optional quantizer dither is enabled by defining SD_MOD_DITHER_EN.
module sd_modulator_tx #(
   parameter int ORDER       = 2,
   parameter int INPUT_WIDTH = 16,
   parameter int OSR         = 200,
   parameter int CLK_DIV     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic signed [INPUT_WIDTH-1:0] data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic                          sd_clk_o,
   output logic                          sd_data_o,
   output logic                          frame_o,
   output logic                          overload_o
);

   localparam int N  = INPUT_WIDTH;
   localparam int W1 = N + 3;
   localparam int W2 = N + 6;
   localparam int A1 = W1 + 2;
   localparam int A2 = W2 + 2;
   localparam int QW = W2 + 2;
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(OSR);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [DW-1:0] DIV_STEP = DW'(CLK_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(OSR - 1);

   localparam logic signed [A1-1:0] FS1  = A1'(1) << (N - 1);
   localparam logic signed [A1-1:0] MAX1 = (A1'(1) << (W1 - 1)) - A1'(1);
   localparam logic signed [A1-1:0] MIN1 = -MAX1;
   localparam logic signed [A2-1:0] FS2  = A2'(1) << (N - 1);
   localparam logic signed [A2-1:0] MAX2 = (A2'(1) << (W2 - 1)) - A2'(1);
   localparam logic signed [A2-1:0] MIN2 = -MAX2;

   logic [DW-1:0]        div_cnt;
   logic [DW-1:0]        div_nxt;
   logic [BW-1:0]        bit_cnt;
   logic signed [N-1:0]  active;
   logic signed [N-1:0]  pending;
   logic                 pending_full;
   logic signed [W1-1:0] i1;
   logic signed [W1-1:0] i1_nxt;
   logic signed [W2-1:0] i2;
   logic signed [W2-1:0] i2_nxt;
   logic signed [A1-1:0] i1_e;
   logic signed [A1-1:0] x_e;
   logic signed [A1-1:0] fb1;
   logic signed [A1-1:0] sum1;
   logic signed [A2-1:0] i2_e;
   logic signed [A2-1:0] i1n_e;
   logic signed [A2-1:0] fb2;
   logic signed [A2-1:0] sum2;
   logic signed [QW-1:0] quant;
   logic                 sat1;
   logic                 sat2;
   logic                 step;
   logic                 wrap;
   logic                 accept;
   logic                 bit_nxt;

`ifdef SD_MOD_DITHER_EN
   localparam logic signed [QW-1:0] DITH_OFS = QW'(8);
   logic [15:0]          lfsr;
   logic signed [QW-1:0] dith;
`endif

   always_comb begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      step    = (div_cnt == DIV_STEP);
      wrap    = step && (bit_cnt == BIT_LAST);
      accept  = valid_i && ready_o;
   end

   // Feedback always uses the bit currently on sd_data_o, i.e. the previous decision.
   always_comb begin
      i1_e   = {{(A1-W1){i1[W1-1]}}, i1};
      x_e    = {{(A1-N){active[N-1]}}, active};
      fb1    = sd_data_o ? FS1 : MIN1 + MAX1 - FS1;
      sum1   = i1_e + x_e - fb1;
      sat1   = 1'b0;
      i1_nxt = sum1[W1-1:0];
      if (sum1 > MAX1) begin
         i1_nxt = MAX1[W1-1:0];
         sat1   = 1'b1;
      end else if (sum1 < MIN1) begin
         i1_nxt = MIN1[W1-1:0];
         sat1   = 1'b1;
      end

      i2_e   = {{(A2-W2){i2[W2-1]}}, i2};
      i1n_e  = {{(A2-W1){i1_nxt[W1-1]}}, i1_nxt};
      fb2    = sd_data_o ? FS2 : MIN2 + MAX2 - FS2;
      sum2   = i2_e + i1n_e - fb2;
      sat2   = 1'b0;
      i2_nxt = sum2[W2-1:0];
      if (sum2 > MAX2) begin
         i2_nxt = MAX2[W2-1:0];
         sat2   = 1'b1;
      end else if (sum2 < MIN2) begin
         i2_nxt = MIN2[W2-1:0];
         sat2   = 1'b1;
      end

      if (ORDER == 2) begin
         quant = {{(QW-W2){i2_nxt[W2-1]}}, i2_nxt};
      end else begin
         quant = {{(QW-W1){i1_nxt[W1-1]}}, i1_nxt};
      end
`ifdef SD_MOD_DITHER_EN
      dith  = {{(QW-4){1'b0}}, lfsr[3:0]};
      quant = quant + dith - DITH_OFS;
`endif
      bit_nxt = ~quant[QW-1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt      <= '0;
         bit_cnt      <= '0;
         sd_clk_o     <= 1'b0;
         sd_data_o    <= 1'b0;
         frame_o      <= 1'b0;
         overload_o   <= 1'b0;
         ready_o      <= 1'b0;
         active       <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         i1           <= '0;
         i2           <= '0;
`ifdef SD_MOD_DITHER_EN
         lfsr         <= 16'hACE1;
`endif
      end else begin
         div_cnt  <= div_nxt;
         sd_clk_o <= (div_nxt < DIV_HALF);
         frame_o  <= 1'b0;

         if (step) begin
            i1        <= i1_nxt;
            sd_data_o <= bit_nxt;
            if (ORDER == 2) begin
               i2 <= i2_nxt;
            end
            if (sat1 || (ORDER == 2 && sat2)) begin
               overload_o <= 1'b1;
            end
`ifdef SD_MOD_DITHER_EN
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
            if (bit_cnt == BIT_LAST) begin
               bit_cnt <= '0;
               frame_o <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end

         // The wrap step itself still modulates the old sample; the new one applies from the next step.
         if (accept) begin
            pending      <= data_i;
            pending_full <= 1'b1;
            ready_o      <= 1'b0;
         end else if (wrap && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
            ready_o      <= 1'b1;
         end else begin
            ready_o <= !pending_full;
         end
      end
   end

endmodule

// File: tb/tb_sd_modulator_tx.sv
// Randomized bench for sd_modulator_tx against a time-indexed behavioural modulator model.
module tb_sd_modulator_tx;

   localparam int     N     = 16;
   localparam int     ORDER = 2;
   localparam int     OSR   = 200;
   localparam int     CD    = 4;
   localparam int     HALF  = CD / 2;
   localparam longint FS    = 64'sd1 << (N - 1);
   localparam longint MAX1  = (64'sd1 << (N + 2)) - 1;
   localparam longint MAX2  = (64'sd1 << (N + 5)) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic signed [N-1:0] data = '0;
   logic                valid = 1'b0;
   logic                ready;
   logic                sd_clk;
   logic                sd_data;
   logic                frame;
   logic                overload;

   int errors = 0;
   int checks = 0;

   longint      m_i1, m_i2;
   int          m_act, m_pend;
   bit          m_bit, m_pfull, m_ready, m_frame, m_sdclk, m_ovl;
   logic [15:0] m_lfsr;
   longint      cnt, steps;
   longint      cyc = 0;
   longint      last_frame = -1;

   sd_modulator_tx #(
      .ORDER(ORDER), .INPUT_WIDTH(N), .OSR(OSR), .CLK_DIV(CD)
   ) dut (
      .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
      .sd_clk_o(sd_clk), .sd_data_o(sd_data), .frame_o(frame), .overload_o(overload)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   function automatic longint clip(input longint v, input longint lim, inout bit ovl);
      if (v > lim) begin
         ovl = 1'b1;
         return lim;
      end
      if (v < -lim) begin
         ovl = 1'b1;
         return -lim;
      end
      return v;
   endfunction

   // Model is indexed by elapsed clocks since reset: bit step k happens at clock CD*k+HALF.
   task automatic model_edge(input bit r, input bit v, input int d);
      longint fb, q;
      bit acc;
      if (r) begin
         cnt = 0; steps = 0; m_i1 = 0; m_i2 = 0; m_bit = 0; m_act = 0;
         m_pfull = 0; m_pend = 0; m_ready = 0; m_frame = 0; m_sdclk = 0; m_ovl = 0;
         m_lfsr = 16'hACE1;
         return;
      end
      acc = v && m_ready;
      cnt++;
      m_sdclk = (cnt % CD) < HALF;
      m_frame = 0;
      if (cnt % CD == HALF) begin
         fb   = m_bit ? FS : -FS;
         m_i1 = clip(m_i1 + m_act - fb, MAX1, m_ovl);
         if (ORDER == 2) begin
            m_i2 = clip(m_i2 + m_i1 - fb, MAX2, m_ovl);
            q    = m_i2;
         end else begin
            q = m_i1;
         end
`ifdef SD_MOD_DITHER_EN
         q = q + longint'(m_lfsr[3:0]) - 8;
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
         m_bit = (q >= 0);
         if (steps % OSR == OSR - 1) begin
            m_frame = 1;
            if (m_pfull) begin
               m_act   = m_pend;
               m_pfull = 0;
            end
         end
         steps++;
      end
      if (acc) begin
         m_pfull = 1;
         m_pend  = d;
      end
      m_ready = !m_pfull;
   endtask

   task automatic tick(input bit r, input bit v, input int d);
      rst   = r;
      valid = v;
      data  = N'(d);
      @(posedge clk);
      model_edge(r, v, d);
      #1;
      cyc++;
      check_val("sd_clk", sd_clk, m_sdclk);
      check_val("sd_data", sd_data, m_bit);
      check_val("frame", frame, m_frame);
      check_val("ready", ready, m_ready);
      check_val("overload", overload, m_ovl);
      if (r) begin
         last_frame = -1;
      end else if (frame === 1'b1) begin
         if (last_frame >= 0) check_val("frame_period", 32'(cyc - last_frame), OSR * CD);
         last_frame = cyc;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0);
   endtask

   task automatic send(input int d);
      bit acc = 0;
      for (int t = 0; t < 2 * OSR * CD && !acc; t++) begin
         acc = m_ready;
         tick(0, 1, d);
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got=not_accepted exp=accepted value=%0d", d);
      end
   endtask

   initial begin
      int d;
      for (int i = 0; i < 3; i++) tick(1, 0, 0);

      for (int k = 0; k < 8; k++) begin
         d = int'($urandom_range(32000)) - 16000;
         send(d);
         idle(int'($urandom_range(900)));
      end

      // back-to-back: second sample stalls until the wrap
      send(int'($urandom_range(20000)) - 10000);
      send(int'($urandom_range(20000)) - 10000);
      idle(3 * OSR * CD);

      // reset one clock mid-frame with a pending sample
      for (int t = 0; t < OSR * CD + 10 && !m_frame; t++) tick(0, 0, 0);
      send(12345);
      idle(300);
      tick(1, 0, 0);
      check_val("ready_after_rst", ready, 0);
      tick(0, 0, 0);
      check_val("ready_rst_release", ready, 1);
      idle(3 * OSR * CD);

      // full-scale limits and sticky overload
      send(-32768);
      idle(2 * OSR * CD);
      send(32767);
      idle(3 * OSR * CD);
      check_val("ovl_set", overload, 1);
      send(0);
      idle(2 * OSR * CD);
      check_val("ovl_sticky", overload, 1);
      tick(1, 0, 0);
      check_val("ovl_cleared", overload, 0);
      idle(OSR * CD + 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
